// File: rtl/ddr3_test_pkg.sv
// Shared DDR3 exercise types: checker FSM states, default beat geometry and the
// deterministic read/write data pattern used by both the write generator and the checker.
package ddr3_test_pkg;

    localparam int unsigned DDR3_DATA_W  = 64;
    localparam int unsigned DDR3_BEATS_W = 16;
    // Widest half-beat the word replicator can cover (DATA_W up to 512).
    localparam int unsigned PAT_REP_W    = 256;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_FLUSH,
        ST_DONE
    } chk_state_e;

    function automatic logic [31:0] pattern_word(input logic [31:0] seed, input logic [31:0] k);
        return seed + k;
    endfunction

    function automatic logic [PAT_REP_W-1:0] rep_word(input logic [31:0] w);
        return {(PAT_REP_W / 32){w}};
    endfunction

    // Beat k: upper half carries seed+k, lower half its complement.
    function automatic logic [DDR3_DATA_W-1:0] pattern(input logic [31:0] seed, input logic [31:0] k);
        logic [31:0]          w;
        logic [PAT_REP_W-1:0] hi;
        logic [PAT_REP_W-1:0] lo;
        w  = pattern_word(seed, k);
        hi = rep_word(w);
        lo = rep_word(~w);
        return {hi[DDR3_DATA_W/2-1:0], lo[DDR3_DATA_W/2-1:0]};
    endfunction

endpackage

// File: rtl/ddr3_pattern_gen.sv
// Expected-beat generator: holds the run seed and beat index, presents the
// expected beat for the current index and advances on each accepted beat.
module ddr3_pattern_gen
    import ddr3_test_pkg::*;
#(
    parameter int unsigned DATA_W  = DDR3_DATA_W,
    parameter int unsigned BEATS_W = DDR3_BEATS_W
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               load,
    input  logic [31:0]        seed,
    input  logic               adv,
    output logic [BEATS_W-1:0] k,
    output logic [DATA_W-1:0]  exp_beat_c
);

    localparam int unsigned HALF_W = DATA_W / 2;

    logic [31:0]          seed_q;
    logic [31:0]          seed_d;
    logic [BEATS_W-1:0]   k_q;
    logic [BEATS_W-1:0]   k_d;
    logic [31:0]          word_c;
    logic [PAT_REP_W-1:0] hi_rep_c;
    logic [PAT_REP_W-1:0] lo_rep_c;

    always_comb begin
        seed_d = seed_q;
        k_d    = k_q;
        if (load) begin
            seed_d = seed;
            k_d    = '0;
        end else if (adv) begin
            k_d = k_q + BEATS_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            seed_q <= '0;
            k_q    <= '0;
        end else begin
            seed_q <= seed_d;
            k_q    <= k_d;
        end
    end

    // Each 32-bit word is replicated, then truncated to half the beat width.
    always_comb begin
        word_c     = pattern_word(seed_q, 32'(k_q));
        hi_rep_c   = rep_word(word_c);
        lo_rep_c   = rep_word(~word_c);
        exp_beat_c = {hi_rep_c[HALF_W-1:0], lo_rep_c[HALF_W-1:0]};
    end

    assign k = k_q;

endmodule

// File: rtl/ddr3_read_checker.sv
// DDR3 local read-port checker: compares returned beats to the seeded pattern,
// counts mismatches, captures the first failure and reports pass/done.
// Optional idle timeout in CHECK is enabled by defining DDR3_CHK_TIMEOUT_EN.
module ddr3_read_checker
    import ddr3_test_pkg::*;
#(
    parameter int unsigned DATA_W      = DDR3_DATA_W,
    parameter int unsigned BEATS_W     = DDR3_BEATS_W,
    parameter int unsigned ERR_W       = 16
`ifdef DDR3_CHK_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 4096
`endif
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic [31:0]        seed,
    input  logic [BEATS_W-1:0] num_beats,
    input  logic [DATA_W-1:0]  read_data,
    input  logic               read_data_valid,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_count,
    output logic [BEATS_W-1:0] first_err_beat,
    output logic [DATA_W-1:0]  first_err_data,
    output logic               spurious,
    output logic               timeout
);

    chk_state_e         state_q;
    chk_state_e         state_d;
    logic [BEATS_W-1:0] num_q;
    logic [BEATS_W-1:0] num_d;
    logic               cmp_vld_q;
    logic               cmp_vld_d;
    logic [DATA_W-1:0]  cmp_data_q;
    logic [DATA_W-1:0]  cmp_data_d;
    logic [DATA_W-1:0]  cmp_exp_q;
    logic [DATA_W-1:0]  cmp_exp_d;
    logic [BEATS_W-1:0] cmp_idx_q;
    logic [BEATS_W-1:0] cmp_idx_d;
    logic               busy_q;
    logic               busy_d;
    logic               done_q;
    logic               done_d;
    logic               pass_q;
    logic               pass_d;
    logic               spurious_q;
    logic               spurious_d;
    logic [ERR_W-1:0]   err_count_q;
    logic [ERR_W-1:0]   err_count_d;
    logic [BEATS_W-1:0] first_err_beat_q;
    logic [BEATS_W-1:0] first_err_beat_d;
    logic [DATA_W-1:0]  first_err_data_q;
    logic [DATA_W-1:0]  first_err_data_d;

    logic               load_c;
    logic               beat_ok_c;
    logic               all_rcvd_c;
    logic [BEATS_W-1:0] k;
    logic [DATA_W-1:0]  exp_beat_c;

    ddr3_pattern_gen #(
        .DATA_W  (DATA_W),
        .BEATS_W (BEATS_W)
    ) u_pattern_gen (
        .clk        (clk),
        .rstn       (rstn),
        .load       (load_c),
        .seed       (seed),
        .adv        (beat_ok_c),
        .k          (k),
        .exp_beat_c (exp_beat_c)
    );

    // Only beats inside the expected count, while in CHECK, are compared.
    assign all_rcvd_c = (k == num_q);
    assign beat_ok_c  = read_data_valid && (state_q == ST_CHECK) && !all_rcvd_c;

`ifdef DDR3_CHK_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] idle_q;
    logic [TO_W-1:0] idle_d;
    logic            timeout_q;
    logic            timeout_d;
    logic            to_hit_c;

    assign to_hit_c = (idle_q == TO_W'(TIMEOUT_CYC));

    always_comb begin
        idle_d = idle_q;
        if ((state_q != ST_CHECK) || beat_ok_c) begin
            idle_d = '0;
        end else if (!to_hit_c) begin
            idle_d = idle_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            idle_q    <= idle_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d          = state_q;
        num_d            = num_q;
        load_c           = 1'b0;
        done_d           = 1'b0;
        pass_d           = pass_q;
        spurious_d       = spurious_q;
        err_count_d      = err_count_q;
        first_err_beat_d = first_err_beat_q;
        first_err_data_d = first_err_data_q;
`ifdef DDR3_CHK_TIMEOUT_EN
        timeout_d        = timeout_q;
`endif
        cmp_vld_d        = beat_ok_c;
        cmp_data_d       = beat_ok_c ? read_data  : cmp_data_q;
        cmp_exp_d        = beat_ok_c ? exp_beat_c : cmp_exp_q;
        cmp_idx_d        = beat_ok_c ? k          : cmp_idx_q;

        // CHECK exits once every beat is in; its last compare retires on that same edge.
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load_c           = 1'b1;
                    num_d            = num_beats;
                    pass_d           = 1'b0;
                    spurious_d       = 1'b0;
                    err_count_d      = '0;
                    first_err_beat_d = '0;
                    first_err_data_d = '0;
`ifdef DDR3_CHK_TIMEOUT_EN
                    timeout_d        = 1'b0;
`endif
                    state_d          = (num_beats == '0) ? ST_FLUSH : ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (all_rcvd_c) begin
                    state_d = ST_FLUSH;
                end
`ifdef DDR3_CHK_TIMEOUT_EN
                else if (to_hit_c) begin
                    timeout_d = 1'b1;
                    state_d   = ST_FLUSH;
                end
`endif
            end
            ST_FLUSH: begin
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (cmp_vld_q && (cmp_data_q != cmp_exp_q)) begin
            if (err_count_q == '0) begin
                first_err_beat_d = cmp_idx_q;
                first_err_data_d = cmp_data_q;
            end
            if (err_count_q != '1) begin
                err_count_d = err_count_q + ERR_W'(1);
            end
        end

        if (read_data_valid && !beat_ok_c) begin
            spurious_d = 1'b1;
        end

        if (state_q == ST_FLUSH) begin
            pass_d = (err_count_d == '0) && !spurious_d
`ifdef DDR3_CHK_TIMEOUT_EN
                     && !timeout_d
`endif
                     ;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q          <= ST_IDLE;
            num_q            <= '0;
            cmp_vld_q        <= 1'b0;
            cmp_data_q       <= '0;
            cmp_exp_q        <= '0;
            cmp_idx_q        <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            spurious_q       <= 1'b0;
            err_count_q      <= '0;
            first_err_beat_q <= '0;
            first_err_data_q <= '0;
        end else begin
            state_q          <= state_d;
            num_q            <= num_d;
            cmp_vld_q        <= cmp_vld_d;
            cmp_data_q       <= cmp_data_d;
            cmp_exp_q        <= cmp_exp_d;
            cmp_idx_q        <= cmp_idx_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            pass_q           <= pass_d;
            spurious_q       <= spurious_d;
            err_count_q      <= err_count_d;
            first_err_beat_q <= first_err_beat_d;
            first_err_data_q <= first_err_data_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign spurious       = spurious_q;
    assign err_count      = err_count_q;
    assign first_err_beat = first_err_beat_q;
    assign first_err_data = first_err_data_q;

endmodule

// File: tb/tb_ddr3_read_checker.sv
// Directed bench for ddr3_read_checker: a transaction-level model predicts done
// timing and run results; a negedge monitor compares against the DUT every cycle.
module tb_ddr3_read_checker;

    localparam int unsigned DW = 64;
    localparam int unsigned BW = 16;
    localparam int unsigned EW = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [31:0]   seed = '0;
    logic [BW-1:0] num_beats = '0;
    logic [DW-1:0] read_data = '0;
    logic          read_data_valid = 1'b0;
    logic          busy;
    logic          done;
    logic          pass;
    logic [EW-1:0] err_count;
    logic [BW-1:0] first_err_beat;
    logic [DW-1:0] first_err_data;
    logic          spurious;
    logic          timeout;

    ddr3_read_checker #(
        .DATA_W  (DW),
        .BEATS_W (BW),
        .ERR_W   (EW)
`ifdef DDR3_CHK_TIMEOUT_EN
        ,
        .TIMEOUT_CYC (16)
`endif
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .start           (start),
        .seed            (seed),
        .num_beats       (num_beats),
        .read_data       (read_data),
        .read_data_valid (read_data_valid),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_count       (err_count),
        .first_err_beat  (first_err_beat),
        .first_err_data  (first_err_data),
        .spurious        (spurious),
        .timeout         (timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state for the run in flight.
    bit          armed = 1'b0;
    int          exp_done_at = 0;
    int          exp_busy_lo = 0;
    bit          exp_pass = 1'b0;
    bit          exp_spur = 1'b0;
    int          exp_err = 0;
    int          exp_fbeat = 0;
    logic [63:0] exp_fdata = '0;
    logic [63:0] beats[$];
    int          gaps[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [63:0] model_pat(input logic [31:0] s, input int k);
        logic [31:0] w;
        w = s + 32'(k);
        return {w, ~w};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},   64'(busy), 64'(0));
        chk({tag, "_done"},   64'(done), 64'(0));
        chk({tag, "_pass"},   64'(pass), 64'(0));
        chk({tag, "_err"},    64'(err_count), 64'(0));
        chk({tag, "_fbeat"},  64'(first_err_beat), 64'(0));
        chk({tag, "_fdata"},  first_err_data, 64'(0));
        chk({tag, "_spur"},   64'(spurious), 64'(0));
        chk({tag, "_tmo"},    64'(timeout), 64'(0));
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("busy", 64'(busy), 64'((cyc >= exp_busy_lo) && (cyc <= exp_done_at)));
            chk("done", 64'(done), 64'(cyc == exp_done_at));
            if (cyc == exp_done_at) begin
                chk("pass",       64'(pass), 64'(exp_pass));
                chk("err_count",  64'(err_count), 64'(exp_err));
                chk("first_beat", 64'(first_err_beat), 64'(exp_fbeat));
                chk("first_data", first_err_data, exp_fdata);
                chk("spurious",   64'(spurious), 64'(exp_spur));
                chk("timeout",    64'(timeout), 64'(0));
            end
        end
    end

    // Drives one run from beats[]/gaps[]; spur_start adds a beat alongside start,
    // spur_tail adds one beat right after the last expected one.
    task automatic run(input logic [31:0] sd, input bit spur_start, input bit spur_tail);
        int n;
        int s;
        int sum_gap;
        n       = beats.size();
        sum_gap = 0;
        exp_err = 0;
        exp_fbeat = 0;
        exp_fdata = '0;
        for (int j = 0; j < n; j++) begin
            if (j < gaps.size()) sum_gap += gaps[j];
            if (beats[j] !== model_pat(sd, j)) begin
                if (exp_err == 0) begin
                    exp_fbeat = j;
                    exp_fdata = beats[j];
                end
                exp_err++;
            end
        end
        exp_spur = spur_start || (spur_tail && n > 0);
        exp_pass = (exp_err == 0) && !exp_spur;

        tick();
        s           = cyc;
        exp_busy_lo = s + 1;
        exp_done_at = (n == 0) ? s + 2 : s + n + sum_gap + 3;
        armed       = 1'b1;
        start           = 1'b1;
        seed            = sd;
        num_beats       = BW'(n);
        read_data_valid = spur_start;
        read_data       = 64'hDEAD_BEEF_0BAD_F00D;
        for (int j = 0; j < n; j++) begin
            if (j < gaps.size()) begin
                for (int g = 0; g < gaps[j]; g++) begin
                    tick();
                    start           = 1'b0;
                    read_data_valid = 1'b0;
                end
            end
            tick();
            start           = 1'b0;
            read_data_valid = 1'b1;
            read_data       = beats[j];
        end
        if (spur_tail && n > 0) begin
            tick();
            read_data_valid = 1'b1;
            read_data       = 64'h1234_5678_9ABC_DEF0;
        end
        tick();
        start           = 1'b0;
        read_data_valid = 1'b0;
        while (cyc < exp_done_at + 2) tick();
        @(negedge clk);
        armed = 1'b0;
    endtask

    task automatic fill_clean(input logic [31:0] sd, input int n);
        beats.delete();
        gaps.delete();
        for (int j = 0; j < n; j++) beats.push_back(model_pat(sd, j));
    endtask

    initial begin
        bit seen;

        // Reset state
        rstn = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check_all_zero("reset");
        tick();
        rstn = 1'b1;
        repeat (2) tick();

        // Clean run, consecutive beats
        fill_clean(32'h0000_1000, 4);
        run(32'h0000_1000, 1'b0, 1'b0);
        chk("clean_pass", 64'(pass), 64'(1));
        chk("clean_err",  64'(err_count), 64'(0));
        chk("clean_spur", 64'(spurious), 64'(0));

        // Two corrupted beats out of 8, with idle gaps between beats
        fill_clean(32'hA5A5_0000, 8);
        beats[2] = beats[2] ^ 64'h1;
        beats[5] = beats[5] ^ (64'h1 << 40);
        gaps = '{0, 1, 0, 2, 0, 0, 3, 0};
        run(32'hA5A5_0000, 1'b0, 1'b0);
        chk("corrupt_err",   64'(err_count), 64'(2));
        chk("corrupt_fbeat", 64'(first_err_beat), 64'(2));
        chk("corrupt_fdata", first_err_data, 64'hA5A5_0002_5A5A_FFFC);
        chk("corrupt_pass",  64'(pass), 64'(0));

        // 32-bit wrap of seed+k, beats written out by hand
        beats.delete();
        gaps.delete();
        beats.push_back(64'hFFFF_FFFE_0000_0001);
        beats.push_back(64'hFFFF_FFFF_0000_0000);
        beats.push_back(64'h0000_0000_FFFF_FFFF);
        beats.push_back(64'h0000_0001_FFFF_FFFE);
        run(32'hFFFF_FFFE, 1'b0, 1'b0);
        chk("wrap_pass", 64'(pass), 64'(1));
        chk("wrap_err",  64'(err_count), 64'(0));

        // Zero-beat run, then a stray beat after done
        beats.delete();
        gaps.delete();
        run(32'h0000_0055, 1'b0, 1'b0);
        chk("zero_pass", 64'(pass), 64'(1));
        tick();
        read_data_valid = 1'b1;
        tick();
        read_data_valid = 1'b0;
        @(negedge clk);
        chk("stray_spur", 64'(spurious), 64'(1));
        repeat (3) tick();
        @(negedge clk);
        chk("stray_spur_held", 64'(spurious), 64'(1));
        chk("stray_pass_held", 64'(pass), 64'(1));
        chk("stray_busy",      64'(busy), 64'(0));

        // Beat in the same cycle as start
        fill_clean(32'h0000_2222, 2);
        run(32'h0000_2222, 1'b1, 1'b0);
        chk("start_beat_pass", 64'(pass), 64'(0));

        // Beat beyond num_beats
        fill_clean(32'h0BAD_0000, 3);
        run(32'h0BAD_0000, 1'b0, 1'b1);
        chk("tail_beat_spur", 64'(spurious), 64'(1));

        // Clean run clears the earlier spurious flag
        fill_clean(32'h7777_7770, 3);
        gaps = '{2, 0, 1};
        run(32'h7777_7770, 1'b0, 1'b0);
        chk("after_spur_pass", 64'(pass), 64'(1));

        // Reset mid-run after 3 of 8 beats (beat 0 corrupted)
        tick();
        start     = 1'b1;
        seed      = 32'h0000_3000;
        num_beats = BW'(8);
        for (int j = 0; j < 3; j++) begin
            tick();
            start           = 1'b0;
            read_data_valid = 1'b1;
            read_data       = (j == 0) ? (model_pat(32'h0000_3000, j) ^ 64'h80) : model_pat(32'h0000_3000, j);
        end
        tick();
        read_data_valid = 1'b0;
        @(negedge clk);
        chk("midrun_busy", 64'(busy), 64'(1));
        chk("midrun_err",  64'(err_count), 64'(1));
        tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        chk("midrst_no_done", 64'(seen), 64'(0));
        fill_clean(32'h0000_3000, 8);
        run(32'h0000_3000, 1'b0, 1'b0);
        chk("post_rst_pass", 64'(pass), 64'(1));

        // Beats stop after 2 of 4
        tick();
        start     = 1'b1;
        seed      = 32'h0000_0300;
        num_beats = BW'(4);
        for (int j = 0; j < 2; j++) begin
            tick();
            start           = 1'b0;
            read_data_valid = 1'b1;
            read_data       = model_pat(32'h0000_0300, j);
        end
        tick();
        read_data_valid = 1'b0;
        seen = 1'b0;
`ifdef DDR3_CHK_TIMEOUT_EN
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("tmo_done_seen", 64'(seen), 64'(1));
        chk("tmo_flag",      64'(timeout), 64'(1));
        chk("tmo_pass",      64'(pass), 64'(0));
        chk("tmo_err",       64'(err_count), 64'(0));
        @(negedge clk);
        chk("tmo_done_pulse", 64'(done), 64'(0));
`else
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        chk("stall_no_done", 64'(seen), 64'(0));
        chk("stall_busy",    64'(busy), 64'(1));
        chk("stall_tmo",     64'(timeout), 64'(0));
        tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        @(negedge clk);
        check_all_zero("stall_rst");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
